// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state encoding and constants for the one-shot pulse generator
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_ACTIVE
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int CNT_TC    = 1;

endpackage

// File: rtl/pulse_gen_if.sv
// pulse_gen_if: trigger/configuration inputs and pulse/status outputs of pulse_gen
interface pulse_gen_if
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             i_trig;
    logic [CNT_W-1:0] i_delay;
    logic [CNT_W-1:0] i_width;
    logic             o_pulse;
    logic             o_busy;
    logic             o_done;
    logic             o_miss;

    modport master (
        output i_trig, i_delay, i_width,
        input  o_pulse, o_busy, o_done, o_miss
    );

    modport slave (
        input  i_trig, i_delay, i_width,
        output o_pulse, o_busy, o_done, o_miss
    );
endinterface

// File: rtl/pulse_gen_dcnt.sv
// pulse_gen_dcnt: loadable down-counter with terminal-count (==1) flag, shared by DELAY and ACTIVE
module pulse_gen_dcnt
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    // load wins over decrement; holding at zero keeps the counter from wrapping
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_tc = (r_cnt == CNT_W'(CNT_TC));
endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: one-shot trigger-to-pulse generator with programmable delay and width (retrigger in ACTIVE when PULSE_GEN_RETRIG_EN is defined)
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    pulse_gen_if.slave  bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_w;
    logic [CNT_W-1:0] w_w;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;
    logic             r_miss;
    logic             w_load;
    logic             w_en;
    logic [CNT_W-1:0] w_val;
    logic             w_tc;
    logic             w_done;
    logic             w_miss;

    pulse_gen_dcnt #(.CNT_W(CNT_W)) u_dcnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_load (w_load),
        .i_en   (w_en),
        .i_val  (w_val),
        .o_tc   (w_tc)
    );

    // state, width latch and outputs; outputs are derived from the next state so they align with it
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_w     <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_w     <= w_w;
            r_pulse <= (w_next == ST_ACTIVE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= w_done;
            r_miss  <= w_miss;
        end
    end

    // next state, counter control and strobe decisions; zero loads bypass their phase entirely
    always_comb begin
        w_next = r_state;
        w_w    = r_w;
        w_load = 1'b0;
        w_en   = 1'b0;
        w_val  = '0;
        w_done = 1'b0;
        w_miss = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_trig) begin
                    w_w = bus.i_width;
                    if (bus.i_delay != '0) begin
                        w_next = ST_DELAY;
                        w_load = 1'b1;
                        w_val  = bus.i_delay;
                    end else if (bus.i_width != '0) begin
                        w_next = ST_ACTIVE;
                        w_load = 1'b1;
                        w_val  = bus.i_width;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                w_en   = 1'b1;
                w_miss = bus.i_trig;
                if (w_tc) begin
                    w_next = (r_w != '0) ? ST_ACTIVE : ST_IDLE;
                    w_load = (r_w != '0);
                    w_val  = r_w;
                    w_done = (r_w == '0);
                end
            end
            ST_ACTIVE: begin
                w_en = 1'b1;
`ifdef PULSE_GEN_RETRIG_EN
                if (bus.i_trig) begin
                    w_w    = bus.i_width;
                    w_next = (bus.i_width != '0) ? ST_ACTIVE : ST_IDLE;
                    w_load = (bus.i_width != '0);
                    w_val  = bus.i_width;
                    w_done = (bus.i_width == '0);
                end else if (w_tc) begin
                    w_next = ST_IDLE;
                    w_done = 1'b1;
                end
`else
                w_miss = bus.i_trig;
                if (w_tc) begin
                    w_next = ST_IDLE;
                    w_done = 1'b1;
                end
`endif
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.o_pulse = r_pulse;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_miss  = r_miss;
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed self-checking bench for pulse_gen
module tb_pulse_gen;
    import pulse_gen_pkg::*;

`ifdef PULSE_GEN_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pulse_gen_if #(.CNT_W(8)) bus ();

    pulse_gen #(.CNT_W(8)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.o_pulse, bus.o_busy, bus.o_done, bus.o_miss};
    endfunction

    // trigger with (d,w); optionally a second trigger sampled r edges later with width wn
    task automatic run_seq(input int d, input int w, input int r, input int wn);
        bit acc;
        int e;
        int hi;
        acc = RETRIG && r > 0 && (r - 1) >= d && (r - 1) < d + w;
        e   = acc ? r + wn : d + w;
        hi  = 0;
        bus.i_trig  = 1'b1;
        bus.i_delay = 8'(d);
        bus.i_width = 8'(w);
        step();
        bus.i_trig = 1'b0;
        for (int j = 0; j <= e; j++) begin
            if (j > 0) step();
            if (bus.o_pulse === 1'b1) hi++;
            chk($sformatf("seq D%0d W%0d r%0d j%0d {pulse,busy,done,miss}", d, w, r, j), 16'(outs()),
                16'({(j >= d && j < e), (j < e), (j == e), (r > 0 && j == r && !acc)}));
            bus.i_trig = (r > 0 && j == r - 1);
            if (r > 0 && j == r - 1) bus.i_width = 8'(wn);
        end
        bus.i_trig = 1'b0;
        chk($sformatf("pulse_len D%0d W%0d", d, w), 16'(hi), 16'(e - d));
    endtask

    initial begin
        bus.i_trig  = 1'b1;
        bus.i_delay = 8'd3;
        bus.i_width = 8'd5;
        #1;
        chk("reset_t0", 16'(outs()), 16'h0);
        step();
        step();
        chk("reset_held_trig", 16'(outs()), 16'h0);
        bus.i_trig = 1'b0;
        #2 i_rstn = 1'b1;
        step();
        chk("after_reset", 16'(outs()), 16'h0);

        run_seq(3, 5, 0, 0);
        step();
        chk("idle_gap", 16'(outs()), 16'h0);
        run_seq(0, 1, 0, 0);
        run_seq(0, 0, 0, 0);
        step();
        run_seq(2, 4, 4, 6);
        step();
        run_seq(3, 2, 0, 0);
        run_seq(2, 3, 0, 0);
        run_seq(1, 0, 0, 0);
        step();
        chk("idle_after_chain", 16'(outs()), 16'h0);
        run_seq(255, 255, 0, 0);
        step();

        bus.i_trig  = 1'b1;
        bus.i_delay = 8'd0;
        bus.i_width = 8'd10;
        step();
        bus.i_trig = 1'b0;
        for (int j = 1; j < 5; j++) step();
        chk("mid_active", 16'(outs()), 16'b1100);
        #2 i_rstn = 1'b0;
        #1;
        chk("async_reset_drop", 16'(outs()), 16'h0);
        step();
        chk("in_reset", 16'(outs()), 16'h0);
        #2 i_rstn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            chk($sformatf("no_done_after_abort j%0d", j), 16'(outs()), 16'h0);
        end
        run_seq(1, 2, 0, 0);
        step();
        chk("final_idle", 16'(outs()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_gen.md
# pulse_gen

One-shot pulse generator: converts a single-cycle trigger strobe into a level pulse of programmable delay and width. It is the pulse-to-level counterpart of the level-to-pulse edge detection used in the counter/shift-register designs. It drives strobes, LEDs and enables that need a stretched, timed level. Typical use is behind a button edge or timer tick.

## Interface
- CNT_W, 8, width of the delay/width counters and of i_delay/i_width
- i_clk  input  1  system clock, all logic on rising edge
- i_rstn  input  1  reset, asynchronous, active-low
- i_trig  input  1  trigger strobe, sampled on each rising edge
- i_delay  input  CNT_W  cycles from trigger acceptance to pulse rise, latched on acceptance
- i_width  input  CNT_W  pulse high time in cycles, latched on acceptance
- o_pulse  output  1  generated pulse level
- o_busy  output  1  high while a trigger is being serviced (DELAY or ACTIVE)
- o_done  output  1  one-cycle strobe when a pulse sequence completes
- o_miss  output  1  one-cycle strobe when a trigger is ignored

## Operation
- States: IDLE, DELAY, ACTIVE.
- IDLE, i_trig=1:
  - latch i_delay as D and i_width as W;
  - D>0: go to DELAY, counter=D;
  - D=0 and W>0: go to ACTIVE, counter=W;
  - D=0 and W=0: stay IDLE and pulse o_done next cycle.
- DELAY: decrement each cycle.
  - At counter==1: W>0 goes to ACTIVE with counter=W; W=0 goes to IDLE with o_done.
- ACTIVE: o_pulse=1. Decrement each cycle; at counter==1 go to IDLE and assert o_done for one cycle.
- A trigger while busy (DELAY or ACTIVE, including the final cycle) is ignored and o_miss pulses for one cycle. The exception is retrigger mode (see Configuration).
- Counters are unsigned CNT_W bits. Maximum delay and width are 2^CNT_W−1. Counters never wrap, because loads of 0 are bypassed as described above.
- Reset (asynchronous, any time, including mid-pulse):
  - state goes to IDLE;
  - counters and latches go to 0;
  - o_pulse, o_busy, o_done and o_miss go to 0 immediately.
  - No o_done is issued for an aborted sequence.

## Timing
- All outputs are registered, and all outputs reset to 0.
- Trigger accepted at edge k:
  - o_busy rises after edge k;
  - o_pulse rises after edge k+D;
  - o_pulse is high for exactly W cycles and falls after edge k+D+W.
- o_done is high for the single cycle after edge k+D+W, coincident with o_pulse low. o_busy falls at the same edge.
- A new trigger is accepted on the cycle o_done is high. Back-to-back sequences therefore have a minimum 1-cycle gap in o_pulse.
- o_miss is high for the cycle after the edge that sampled the ignored trigger.

## Configuration
- PULSE_GEN_RETRIG_EN defined:
  - i_trig=1 in ACTIVE reloads counter with the current i_width, with no o_miss.
  - o_pulse stays high without a glitch and ends W_new cycles after the retrigger edge.
  - A retrigger with i_width=0 ends the pulse at the next edge with o_done.
  - Triggers in DELAY are still missed.
- PULSE_GEN_RETRIG_EN undefined: every trigger while busy produces o_miss and has no other effect.

## Structure
- Package pulse_gen_pkg holds:
  - the state enum (IDLE, DELAY, ACTIVE);
  - the default CNT_W;
  - a constant for counter-terminal value 1.
- One sub-module, pulse_gen_dcnt: a loadable CNT_W down-counter with load, enable and terminal-count (==1) flag. It is shared between the DELAY and ACTIVE phases.
- The FSM, latches and output registers live in the top.

## Test plan
- Reset checks:
  - outputs are 0 during and after reset;
  - i_trig pulse with D=3, W=5: o_busy rises after edge k, o_pulse is high at edges k+4..k+8, o_done is high for 1 cycle after edge k+8.
- D=0, W=1: o_pulse is high for exactly 1 cycle after the trigger edge. With D=0, W=0: o_pulse is never high and o_done appears 1 cycle after the trigger.
- D=2, W=4, second trigger at ACTIVE cycle 2:
  - RETRIG undefined: o_miss for 1 cycle and the pulse is still 4 cycles;
  - RETRIG defined, i_width=6: pulse totals 2+6=8 cycles with no o_miss.
- Trigger on the o_done cycle is accepted: the next pulse starts after D cycles and o_miss stays 0. Max values D=255, W=255 (CNT_W=8) give a pulse exactly 255 cycles long with no wrap.
- Assert i_rstn low asynchronously mid-ACTIVE (W=10, cycle 5):
  - o_pulse and o_busy drop without waiting for a clock;
  - no o_done is issued;
  - a subsequent trigger behaves normally.
